// File: rtl/div.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU; returns {remainder, quotient}, one bit per clock.
// Define DIV_SIGNED_EN to honour signed_div_i; when undefined every divide is unsigned.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] divisor_q, divisor_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] mag1, mag2;
  logic [31:0] quot_fix, rem_fix;
  logic [32:0] shifted;
  logic        fits;

`ifdef DIV_SIGNED_EN
  logic neg_quot_q, neg_rem_q;
  logic load;

  assign load = (state_q == StFree) && start_i && !annul_i && (opdata2_i != 32'd0);

  assign mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  assign quot_fix = neg_quot_q ? (~quot_q + 32'd1) : quot_q;
  assign rem_fix  = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

  // Remainder takes the dividend's sign; quotient is negative when signs differ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (load) begin
      neg_quot_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
      neg_rem_q  <= signed_div_i && opdata1_i[31];
    end
  end
`else
  logic unused_signed_div;

  assign unused_signed_div = signed_div_i;
  assign mag1              = opdata1_i;
  assign mag2              = opdata2_i;
  assign quot_fix          = quot_q;
  assign rem_fix           = rem_q;
`endif

  // quot_q starts as the dividend and shifts left, so its MSB is the next dividend bit.
  assign shifted = {rem_q, quot_q[31]};
  assign fits    = shifted >= {1'b0, divisor_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFree;
      cnt_q     <= 6'd0;
      rem_q     <= 32'd0;
      quot_q    <= 32'd0;
      divisor_q <= 32'd0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      StFree: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = StByZero;
          end else begin
            state_d   = StOn;
            cnt_d     = 6'd0;
            rem_d     = 32'd0;
            quot_d    = mag1;
            divisor_d = mag2;
          end
        end
      end
      StByZero: begin
        if (annul_i) begin
          state_d = StFree;
        end else begin
          state_d  = StEnd;
          result_d = 64'd0;
        end
      end
      StOn: begin
        if (annul_i) begin
          state_d = StFree;
        end else if (cnt_q == 6'd32) begin
          state_d  = StEnd;
          ready_d  = 1'b1;
          result_d = {rem_fix, quot_fix};
        end else begin
          // shifted - divisor is below divisor whenever it fits, so 32 bits suffice.
          rem_d  = fits ? 32'(shifted - {1'b0, divisor_q}) : shifted[31:0];
          quot_d = {quot_q[30:0], fits};
          cnt_d  = cnt_q + 6'd1;
        end
      end
      StEnd: begin
        if (start_i) begin
          ready_d = 1'b1;
        end else begin
          state_d  = StFree;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end
      end
      default: state_d = StFree;
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed cases plus random operands against an arithmetic model.
// Expectations follow DIV_SIGNED_EN the same way the design does.
module tb_div;

`ifdef DIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int tests;
  int fails;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Plain-arithmetic reference: SV division truncates toward zero like DIV does.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [31:0] q, r;
    longint      sa, sb;
    if (b == 32'd0) return 64'd0;
    if (sgn && SignedEn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, output logic [63:0] got);
    logic [63:0] exp;
    int          lat;
    int          edges;
    exp        = model(a, b, sgn);
    lat        = (b == 32'd0) ? 2 : 33;
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    start      = 1'b1;
    tick();
    // Operands must be ignored once the start edge has passed.
    opdata1    = $urandom;
    opdata2    = $urandom;
    signed_div = 1'($urandom_range(0, 1));
    edges      = 0;
    while (!ready && edges < 40) begin
      tick();
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'(lat));
    check({tag, " result"}, result, exp);
    got = result;
    tick();
    check({tag, " hold"}, {63'd0, ready} ^ result, {63'd0, 1'b1} ^ exp);
    start = 1'b0;
    tick();
    check({tag, " clear"}, {63'd0, ready} | result, 64'd0);
  endtask

  initial begin
    logic [63:0] got;
    logic        seen_ready;
    logic [31:0] a, b;
    logic        sgn;
    int          r;

    tests      = 0;
    fails      = 0;
    rst        = 1'b0;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    #2;
    check("reset result", result, 64'd0);
    check("reset ready", 64'(ready), 64'd0);
    #10 rst = 1'b1;
    tick();

    run_div("u 100/7", 32'd100, 32'd7, 1'b0, got);
    check("u 100/7 const", got, 64'h00000002_0000000E);
    run_div("s -7/2", 32'hFFFFFFF9, 32'd2, 1'b1, got);
    check("s -7/2 const", got,
          SignedEn ? 64'hFFFFFFFF_FFFFFFFD : 64'h00000001_7FFFFFFC);
    run_div("s min/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, got);
    run_div("by zero", 32'd5, 32'd0, 1'b0, got);

    // Annul at edge 10 of 100/7: no ready, then a fresh 9/3 runs normally.
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start   = 1'b1;
    tick();
    repeat (9) tick();
    annul = 1'b1;
    tick();
    annul      = 1'b0;
    start      = 1'b0;
    seen_ready = 1'b0;
    repeat (40) begin
      tick();
      seen_ready |= ready;
    end
    check("annul no ready", 64'(seen_ready), 64'd0);
    run_div("after annul 9/3", 32'd9, 32'd3, 1'b0, got);
    check("9/3 const", got, 64'h00000000_00000003);

    // Annul in FREE blocks a simultaneous start.
    opdata1 = 32'd50;
    opdata2 = 32'd5;
    start   = 1'b1;
    annul   = 1'b1;
    tick();
    start      = 1'b0;
    annul      = 1'b0;
    seen_ready = 1'b0;
    repeat (40) begin
      tick();
      seen_ready |= ready;
    end
    check("annul blocks start", 64'(seen_ready), 64'd0);

    // Reset at edge 15 of a divide, then a normal divide.
    opdata1 = 32'd100;
    opdata2 = 32'd7;
    start   = 1'b1;
    tick();
    repeat (15) tick();
    rst = 1'b0;
    #1;
    check("reset mid-divide", {63'd0, ready} | result, 64'd0);
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    run_div("after reset 100/7", 32'd100, 32'd7, 1'b0, got);

    // Asynchronous reset while a result is being held.
    opdata1 = 32'd1000;
    opdata2 = 32'd3;
    start   = 1'b1;
    tick();
    r = 0;
    while (!ready && r < 40) begin
      tick();
      r++;
    end
    check("pre-reset ready", 64'(ready), 64'd1);
    rst = 1'b0;
    #1;
    check("async reset", {63'd0, ready} | result, 64'd0);
    start = 1'b0;
    #2 rst = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      r = int'($urandom_range(0, 9));
      a = $urandom;
      if (r == 0) b = 32'd0;
      else if (r < 4) b = 32'($urandom_range(1, 15));
      else if (r < 6) b = -32'($urandom_range(1, 15));
      else b = $urandom;
      sgn = 1'($urandom_range(0, 1));
      run_div($sformatf("rand%0d", i), a, b, sgn, got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
